// File: rtl/adder_pkg.sv
// Shared widths and operand type for the registered 8-bit lookahead adder.
package adder_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int GROUP_DEF = 4;

  typedef logic [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/cla_4.sv
// One 4-bit carry-lookahead group: sum plus group generate/propagate, purely combinational.
// No state, no handshake; latency is zero.
module cla_4
  import adder_pkg::*;
(
  input  logic [GROUP_DEF-1:0] a,
  input  logic [GROUP_DEF-1:0] b,
  input  logic                 cin,
  output logic [GROUP_DEF-1:0] sum,
  output logic                 g,
  output logic                 p
);

  logic [GROUP_DEF-1:0] w_g;
  logic [GROUP_DEF-1:0] w_p;
  logic [GROUP_DEF-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum-of-products of cin and bit g/p; nothing ripples.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;

  assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign p = &w_p;

endmodule

// File: rtl/adder_8.sv
// Registered 8-bit adder: two lookahead groups plus a second-level carry unit.
// Latency 1 clock, accepts new operands every cycle, never stalls.
module adder_8
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             of,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             clk,
  input  logic             rst_n
);

  word_t w_sum;
  logic  w_g_lo, w_p_lo;
  logic  w_g_hi, w_p_hi;
  logic  w_c_hi;
  logic  w_co;
  logic  w_of;

  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_of;

  cla_4 u_cla_lo (
    .a   (a[GROUP-1:0]),
    .b   (b[GROUP-1:0]),
    .cin (ci),
    .sum (w_sum[GROUP-1:0]),
    .g   (w_g_lo),
    .p   (w_p_lo)
  );

  cla_4 u_cla_hi (
    .a   (a[WIDTH-1:GROUP]),
    .b   (b[WIDTH-1:GROUP]),
    .cin (w_c_hi),
    .sum (w_sum[WIDTH-1:GROUP]),
    .g   (w_g_hi),
    .p   (w_p_hi)
  );

  // Second-level lookahead: both group carry-ins come straight from ci and group G/P.
  assign w_c_hi = w_g_lo | (w_p_lo & ci);
  assign w_co   = w_g_hi | (w_p_hi & w_g_lo) | (w_p_hi & w_p_lo & ci);

  assign w_of = (a[WIDTH-1] == b[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s  <= '0;
      r_co <= 1'b0;
      r_of <= 1'b0;
    end else begin
      r_s  <= w_sum;
      r_co <= w_co;
      r_of <= w_of;
    end
  end

  assign s  = r_s;
  assign co = r_co;
  assign of = r_of;

endmodule

// File: tb/tb_adder_8.sv
// Random plus directed stimulus against a signed/unsigned arithmetic model of the adder.
module tb_adder_8;

  logic [7:0] s;
  logic       co;
  logic       of;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic       clk;
  logic       rst_n;

  int n_checks = 0;
  int n_errors = 0;

  adder_8 dut (
    .s     (s),
    .co    (co),
    .of    (of),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packed as {co, of, s}.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mci);
    int u;
    int sv;
    logic [9:0] r;
    u  = int'(ma) + int'(mb) + int'(mci);
    sv = int'($signed(ma)) + int'($signed(mb)) + int'(mci);
    r  = {u[8], (sv > 127 || sv < -128), u[7:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got co=%0b of=%0b s=%02h, want co=%0b of=%0b s=%02h",
               name, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Cycle-by-cycle compare against the model, using inputs seen at the edge.
  always @(posedge clk) begin
    logic [7:0] sa;
    logic [7:0] sb;
    logic       sci;
    logic       srst;
    sa = a; sb = b; sci = ci; srst = rst_n;
    #1;
    if (!rst_n || !srst)
      check("cycle_reset", {co, of, s}, 10'd0);
    else
      check("cycle_model", {co, of, s}, model(sa, sb, sci));
  end

  task automatic apply(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                       input logic [9:0] exp, input string name);
    @(negedge clk);
    a = ta; b = tb; ci = tci;
    @(posedge clk);
    #2;
    check(name, {co, of, s}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    a = 8'h00; b = 8'h00; ci = 1'b0; rst_n = 1'b0;
    #1;
    check("reset_initial", {co, of, s}, 10'd0);

    check("model_pin_7f01", model(8'h7F, 8'h01, 1'b0), {1'b0, 1'b1, 8'h80});
    check("model_pin_ffff1", model(8'hFF, 8'hFF, 1'b1), {1'b1, 1'b0, 8'hFF});
    check("model_pin_8080", model(8'h80, 8'h80, 1'b0), {1'b1, 1'b1, 8'h00});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h55, 8'h55, 1'b0, {1'b0, 1'b1, 8'hAA}, "preload_5555");

    // Async reset mid-cycle, well away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", {co, of, s}, 10'd0);
    repeat (2) @(posedge clk);

    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h00; b = 8'h04; ci = 1'b0;
    @(posedge clk);
    #2;
    check("first_after_reset", {co, of, s}, {1'b0, 1'b0, 8'h04});

    apply(8'hF6, 8'h0A, 1'b0, {1'b1, 1'b0, 8'h00}, "f6_0a");
    apply(8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80}, "7f_01");
    apply(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00}, "80_80");
    apply(8'hFF, 8'h00, 1'b1, {1'b1, 1'b0, 8'h00}, "ff_00_1");
    apply(8'hFF, 8'hFF, 1'b1, {1'b1, 1'b0, 8'hFF}, "ff_ff_1");
    apply(8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00}, "zero");
    apply(8'h80, 8'h7F, 1'b1, {1'b1, 1'b0, 8'h00}, "80_7f_1");
    apply(8'h3C, 8'h44, 1'b1, {1'b0, 1'b1, 8'h81}, "3c_44_1");

    // Random soak, back-to-back, with a reset pulse in the middle.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      if (i == 5000) begin
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_soak_async", {co, of, s}, 10'd0);
      end
      if (i == 5003) rst_n = 1'b1;
    end
    @(posedge clk);
    #3;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
